// File: rtl/instr_encoder.sv
// Packs a field tuple into a katp91 word and writes legal words to program RAM; SPECIAL_LONG adds an extension word.
// One cycle from acceptance to mem_we; mem_we/addr/data held until mem_ready, no new tuple accepted while writing.
module instr_encoder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_group,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_rgv,
    input  logic [2:0]        in_rg1,
    input  logic [2:0]        in_rg2,
    input  logic [7:0]        in_val,
    input  logic [15:0]       in_ext,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              err_illegal,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] cur_addr
);
    localparam logic [3:0] GROUP_CRVMATH       = 4'd0;
    localparam logic [3:0] GROUP_RJMP          = 4'd1;
    localparam logic [3:0] GROUP_CRRMATH       = 4'd2;
    localparam logic [3:0] GROUP_CRSMATH       = 4'd3;
    localparam logic [3:0] GROUP_WRRMATH       = 4'd4;
    localparam logic [3:0] GROUP_WRRMATH_MEM   = 4'd5;
    localparam logic [3:0] GROUP_WRSMATH       = 4'd6;
    localparam logic [3:0] GROUP_WRSMATH_STACK = 4'd7;
    localparam logic [3:0] GROUP_SFLAG         = 4'd8;
    localparam logic [3:0] GROUP_UFLAG         = 4'd9;
    localparam logic [3:0] GROUP_SPECIAL       = 4'd10;
    localparam logic [3:0] GROUP_SPECIAL_LONG  = 4'd11;

    typedef enum logic [1:0] {IDLE, EMIT, EMIT_EXT} state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_mem_we;
    logic              r_err_illegal;
    logic              r_long;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [15:0]       r_mem_wdata;
    logic [15:0]       r_ext;
    logic [7:0]        r_err_count;

    logic [15:0]       w_word;
    logic [6:0]        w_regs;
    logic [4:0]        w_decoded;
    logic              w_legal;
    logic [ADDR_W-1:0] w_base_addr;
    logic [ADDR_W-1:0] w_next_addr;

    // Mirrors the CPU decoder: returns {valid, group} for an opcode and the word's low five bits.
    function automatic logic [4:0] decode_group(input logic [3:0] op, input logic [4:0] low);
        logic mem_op;
        logic top_op;
        mem_op = (op == 4'h8) || (op == 4'h9) || (op == 4'hA) ||
                 (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
        top_op = (op[3:1] == 3'b111);
        decode_group = 5'b0_0000;
        if (!low[4]) begin
            decode_group = {1'b1, GROUP_CRVMATH};
        end else if (!low[3]) begin
            decode_group = {1'b1, GROUP_RJMP};
        end else begin
            case (low[2:0])
                3'b100:  decode_group = {1'b1, GROUP_CRRMATH};
                3'b110:  decode_group = {1'b1, GROUP_CRSMATH};
                3'b101:  decode_group = {1'b1, mem_op ? GROUP_WRRMATH_MEM : GROUP_WRRMATH};
                3'b111:  decode_group = {1'b1, top_op ? GROUP_WRSMATH_STACK : GROUP_WRSMATH};
                3'b000:  decode_group = {1'b1, GROUP_SFLAG};
                3'b001:  decode_group = {1'b1, GROUP_UFLAG};
                3'b011:  decode_group = {1'b1, top_op ? GROUP_SPECIAL_LONG : GROUP_SPECIAL};
                default: decode_group = 5'b0_0000;
            endcase
        end
    endfunction

    always_comb begin
        w_regs = {1'b0, in_rg2, in_rg1};
        case (in_group)
            GROUP_CRVMATH:                          w_word = {in_op, in_val, in_rgv, 1'b0};
            GROUP_RJMP:                             w_word = {in_op, 4'b0000, in_val};
            GROUP_CRRMATH:                          w_word = {in_op, w_regs, 5'b11100};
            GROUP_CRSMATH:                          w_word = {in_op, w_regs, 5'b11110};
            GROUP_WRRMATH, GROUP_WRRMATH_MEM:       w_word = {in_op, w_regs, 5'b11101};
            GROUP_WRSMATH, GROUP_WRSMATH_STACK:     w_word = {in_op, w_regs, 5'b11111};
            GROUP_SFLAG:                            w_word = {in_op, w_regs, 5'b11000};
            GROUP_UFLAG:                            w_word = {in_op, w_regs, 5'b11001};
            GROUP_SPECIAL, GROUP_SPECIAL_LONG:      w_word = {in_op, w_regs, 5'b11011};
            default:                                w_word = 16'h0000;
        endcase
    end

    // Unknown group codes never come back from the decoder, so they fail this compare too.
    assign w_decoded   = decode_group(w_word[15:12], w_word[4:0]);
    assign w_legal     = w_decoded[4] && (w_decoded[3:0] == in_group);
    assign w_base_addr = load_addr ? start_addr : r_cur_addr;
    assign w_next_addr = r_cur_addr + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_in_ready    <= 1'b1;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= 16'h0000;
            r_err_illegal <= 1'b0;
            r_err_count   <= 8'h00;
            r_cur_addr    <= '0;
            r_ext         <= 16'h0000;
            r_long        <= 1'b0;
        end else begin
            r_err_illegal <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load_addr) begin
                        r_cur_addr <= start_addr;
                    end
                    if (in_valid) begin
                        if (w_legal) begin
                            r_mem_addr  <= w_base_addr;
                            r_mem_wdata <= w_word;
                            r_mem_we    <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_ext       <= in_ext;
                            r_long      <= (in_group == GROUP_SPECIAL_LONG);
                            r_state     <= EMIT;
                        end else begin
                            r_err_illegal <= 1'b1;
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (mem_ready) begin
                        r_cur_addr <= w_next_addr;
                        if (r_long) begin
                            r_mem_addr  <= w_next_addr;
                            r_mem_wdata <= r_ext;
                            r_state     <= EMIT_EXT;
                        end else begin
                            r_mem_we   <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end
                EMIT_EXT: begin
                    if (mem_ready) begin
                        r_cur_addr <= w_next_addr;
                        r_mem_we   <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign err_illegal = r_err_illegal;
    assign err_count   = r_err_count;
    assign cur_addr    = r_cur_addr;
endmodule
